// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan controller.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a} patterns, indexed by hex value.
  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef enum logic {DEAD_T, ON} slot_e;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex digit to active-low segment pattern lookup.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TAB[hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Round-robin scan controller for an NDIG-digit active-low 7-segment bank.
// Optional per-digit decimal point enabled by defining SEG_SCAN_DP_EN.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NDIG  = 8,
  parameter int DIV   = 1000,
  parameter int DEAD  = 2,
  parameter int IDX_W = $clog2(NDIG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [3:0]       wr_data,
  input  logic             wr_blank,
`ifdef SEG_SCAN_DP_EN
  input  logic             wr_dp,
  output logic             dp,
`endif
  input  logic             clr,
  output logic [NDIG-1:0]  an,
  output logic [6:0]       seg,
  output logic             frame_tick
);

  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int PW = $clog2(DIV);
  localparam slot_e ST_RST = (DEAD > 0) ? DEAD_T : ON;

  logic [PW-1:0]         pre_q, pre_d;
  logic [CW-1:0]         cur_q, cur_d;
  slot_e                 st_q, st_d;
  logic                  wrap;
  logic [NDIG-1:0][3:0]  data_q;
  logic [NDIG-1:0]       blank_q;
  logic [CW-1:0]         widx;
  logic                  wr_ok;
  logic [NDIG-1:0]       onehot;
  logic [6:0]            dec_seg;
`ifdef SEG_SCAN_DP_EN
  logic [NDIG-1:0]       dp_q;
`endif

  // Slot state tracks the prescaler so outputs can be keyed off st_q alone.
  always_comb begin
    wrap  = (pre_q == PW'(DIV - 1));
    pre_d = wrap ? '0 : pre_q + 1'b1;
    cur_d = cur_q;
    if (wrap) cur_d = (cur_q == CW'(NDIG - 1)) ? '0 : cur_q + 1'b1;
    st_d  = (pre_d < PW'(DEAD)) ? DEAD_T : ON;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
      cur_q <= '0;
      st_q  <= ST_RST;
    end else begin
      pre_q <= pre_d;
      cur_q <= cur_d;
      st_q  <= st_d;
    end
  end

  assign widx  = wr_idx[CW-1:0];
  assign wr_ok = wr_en && ({1'b0, wr_idx} < (IDX_W + 1)'(NDIG));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      blank_q <= '1;
`ifdef SEG_SCAN_DP_EN
      dp_q    <= '0;
`endif
    end else if (clr) begin
      blank_q <= '1;
`ifdef SEG_SCAN_DP_EN
      dp_q    <= '0;
`endif
    end else if (wr_ok) begin
      data_q[widx]  <= wr_data;
      blank_q[widx] <= wr_blank;
`ifdef SEG_SCAN_DP_EN
      dp_q[widx]    <= wr_dp;
`endif
    end
  end

  seg_hex_decode u_dec (
    .hex (data_q[cur_q]),
    .seg (dec_seg)
  );

  assign onehot = {{(NDIG-1){1'b0}}, 1'b1} << cur_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= '1;
      seg        <= SEG_BLANK;
      frame_tick <= 1'b0;
`ifdef SEG_SCAN_DP_EN
      dp         <= 1'b1;
`endif
    end else begin
      an         <= (st_q == ON) ? ~onehot : '1;
      seg        <= (st_q == ON && !blank_q[cur_q]) ? dec_seg : SEG_BLANK;
      frame_tick <= wrap && (cur_q == CW'(NDIG - 1));
`ifdef SEG_SCAN_DP_EN
      dp         <= !(st_q == ON && dp_q[cur_q]);
`endif
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (NDIG=4, DIV=8, DEAD=2, IDX_W=3).
module tb_seg_scan_ctrl;

  localparam int NDIG = 4;
  localparam int DIV  = 8;
  localparam int DEAD = 2;

  logic       clk, rst;
  logic       wr_en, wr_blank, clr;
  logic [2:0] wr_idx;
  logic [3:0] wr_data;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_tick;
  logic       wr_dp;
`ifdef SEG_SCAN_DP_EN
  logic       dp;
`endif

  int checks = 0;
  int failures = 0;

  seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .DEAD(DEAD), .IDX_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_data    (wr_data),
    .wr_blank   (wr_blank),
`ifdef SEG_SCAN_DP_EN
    .wr_dp      (wr_dp),
    .dp         (dp),
`endif
    .clr        (clr),
    .an         (an),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] hex2seg(input int h);
    case (h)
      0: return 7'b1000000;   1: return 7'b1111001;
      2: return 7'b0100100;   3: return 7'b0110000;
      4: return 7'b0011001;   5: return 7'b0010010;
      6: return 7'b0000010;   7: return 7'b1111000;
      8: return 7'b0000000;   9: return 7'b0010000;
      10: return 7'b0001000;  11: return 7'b0000011;
      12: return 7'b1000110;  13: return 7'b0100001;
      14: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // Reference model: slot position as plain integers; outputs lag one clock.
  int         m_pre, m_cur;
  int         m_data [NDIG];
  bit         m_blank [NDIG];
  bit         m_dp [NDIG];
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_ft, e_dp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pre <= 0;
      m_cur <= 0;
      for (int i = 0; i < NDIG; i++) begin
        m_data[i]  <= 0;
        m_blank[i] <= 1'b1;
        m_dp[i]    <= 1'b0;
      end
      e_an  <= 4'hF;
      e_seg <= 7'h7F;
      e_ft  <= 1'b0;
      e_dp  <= 1'b1;
    end else begin
      e_an  <= (m_pre >= DEAD) ? ~(4'b0001 << m_cur) : 4'hF;
      e_seg <= (m_pre >= DEAD && !m_blank[m_cur]) ? hex2seg(m_data[m_cur]) : 7'h7F;
      e_dp  <= !(m_pre >= DEAD && m_dp[m_cur]);
      e_ft  <= (m_pre == DIV - 1) && (m_cur == NDIG - 1);
      m_pre <= (m_pre + 1) % DIV;
      if (m_pre == DIV - 1) m_cur <= (m_cur + 1) % NDIG;
      if (clr) begin
        for (int i = 0; i < NDIG; i++) begin
          m_blank[i] <= 1'b1;
          m_dp[i]    <= 1'b0;
        end
      end else if (wr_en && int'(wr_idx) < NDIG) begin
        m_data[wr_idx]  <= int'(wr_data);
        m_blank[wr_idx] <= wr_blank;
        m_dp[wr_idx]    <= wr_dp;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("an", 32'(an), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("frame_tick", 32'(frame_tick), 32'(e_ft));
`ifdef SEG_SCAN_DP_EN
    chk("dp", 32'(dp), 32'(e_dp));
`endif
  endtask

  task automatic wr(input int idx, input int d, input bit b, input bit p);
    logic [31:0] iv, dv;
    iv = idx;
    dv = d;
    wr_en    = 1'b1;
    wr_idx   = iv[2:0];
    wr_data  = dv[3:0];
    wr_blank = b;
    wr_dp    = p;
    step();
    wr_en    = 1'b0;
  endtask

  int c0, c1, c2, c3, cdead, cother, nft, first_ft, last_ft;

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_data = '0;
    wr_blank = 1'b0; wr_dp = 1'b0; clr = 1'b0;
    #3;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_ft", 32'(frame_tick), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Digits 0..3 = 3, A, 7, 0; then one full frame tallied by pattern.
    wr(0, 3, 0, 0); wr(1, 10, 0, 0); wr(2, 7, 0, 0); wr(3, 0, 0, 0);
    c0 = 0; c1 = 0; c2 = 0; c3 = 0; cdead = 0;
    for (int k = 0; k < 32; k++) begin
      step();
      if (an == 4'b1110 && seg == 7'b0110000) c0++;
      if (an == 4'b1101 && seg == 7'b0001000) c1++;
      if (an == 4'b1011 && seg == 7'b1111000) c2++;
      if (an == 4'b0111 && seg == 7'b1000000) c3++;
      if (an == 4'b1111 && seg == 7'b1111111) cdead++;
    end
    chk("win_d0", c0, 6); chk("win_d1", c1, 6);
    chk("win_d2", c2, 6); chk("win_d3", c3, 6);
    chk("dead_cycles", cdead, 8);

    // Blank digit 1 only.
    wr(1, 10, 1, 0);
    c0 = 0; c1 = 0;
    for (int k = 0; k < 32; k++) begin
      step();
      if (an == 4'b1101 && seg == 7'b1111111) c1++;
      if (an == 4'b1110 && seg == 7'b0110000) c0++;
    end
    chk("blank_d1", c1, 6);
    chk("blank_keeps_d0", c0, 6);

    // Out-of-range index is ignored; frame_tick period is 32.
    wr(5, 9, 0, 0);
    nft = 0; first_ft = -1; last_ft = -1; c0 = 0;
    for (int k = 0; k < 96; k++) begin
      step();
      if (frame_tick) begin
        nft++;
        if (first_ft < 0) first_ft = k;
        last_ft = k;
      end
      if (an == 4'b1110 && seg == 7'b0110000) c0++;
    end
    chk("ft_count", nft, 3);
    chk("ft_period", last_ft - first_ft, 64);
    chk("idx5_ignored_d0", c0, 18);

    // clr beats a simultaneous write.
    clr = 1'b1;
    wr(0, 5, 0, 0);
    clr = 1'b0;
    cother = 0; c0 = 0;
    for (int k = 0; k < 32; k++) begin
      step();
      if (seg != 7'b1111111) cother++;
      if (an != 4'b1111) c0++;
    end
    chk("clr_dark", cother, 0);
    chk("clr_scan_runs", c0, 24);

    // Randomized writes and clears against the model.
    for (int k = 0; k < 300; k++) begin
      wr_en    = 1'($urandom_range(0, 1));
      wr_idx   = 3'($urandom_range(0, 7));
      wr_data  = 4'($urandom_range(0, 15));
      wr_blank = ($urandom_range(0, 3) == 0);
      wr_dp    = 1'($urandom_range(0, 1));
      clr      = ($urandom_range(0, 24) == 0);
      step();
    end
    wr_en = 1'b0; clr = 1'b0;

`ifdef SEG_SCAN_DP_EN
    clr = 1'b1;
    step();
    clr = 1'b0;
    wr(2, 3, 0, 1);
    c0 = 0; cother = 0;
    for (int k = 0; k < 32; k++) begin
      step();
      if (dp == 1'b0) c0++;
      if (dp == 1'b0 && an != 4'b1011) cother++;
    end
    chk("dp_d2_window", c0, 6);
    chk("dp_elsewhere", cother, 0);
`endif

    // Asynchronous reset during the ON window of digit 2.
    for (int k = 0; k < 64 && !(m_cur == 2 && m_pre == 4); k++) step();
    chk("pre_rst_an", 32'(an), 32'b1011);
    #2 rst = 1'b1;
    #1;
    chk("midrst_an", 32'(an), 32'hF);
    chk("midrst_seg", 32'(seg), 32'h7F);
    chk("midrst_ft", 32'(frame_tick), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step(); chk("post_rst_an0", 32'(an), 32'hF);
    step(); chk("post_rst_an1", 32'(an), 32'hF);
    step(); chk("post_rst_on", 32'(an), 32'b1110);
    chk("post_rst_seg", 32'(seg), 32'h7F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed controller for an N-digit, common-anode, active-low 7-segment display bank. It holds one 4-bit hex value and a blank flag per digit and shares a single hex-to-segment decoder among all digits by scanning them round-robin. It includes a dead-time between digit slots to suppress ghosting. It sits between the keyboard/data logic, which writes digits, and the board's segment and anode pins.

Parameters:
NDIG, 8, number of digits scanned (2..16)
DIV, 1000, clk cycles per digit slot (>= DEAD+2)
DEAD, 2, cycles at start of each slot with all anodes off
IDX_W, $clog2(NDIG), width of digit index

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
wr_en  in  1  write strobe, one digit per cycle
wr_idx  in  IDX_W  digit to write; 0 = rightmost
wr_data  in  4  hex value 0..15
wr_blank  in  1  1 = digit dark regardless of wr_data
clr  in  1  synchronous clear: all digits blank
an  out  NDIG  digit enables, active-low, at most one low
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
frame_tick  out  1  one-cycle pulse when scan wraps NDIG-1 -> 0

Behaviour:
- Reset (async, any time, including mid-slot):
  - all digit regs = blank, data 0; pre = 0; cur = 0.
  - an = all 1s; seg = 7'b1111111; frame_tick = 0.
- Prescaler pre: counts 0..DIV-1 and wraps to 0.
- Digit advance: on wrap, cur advances cur+1, NDIG-1 -> 0.
- frame_tick: asserted in the cycle after the advance from NDIG-1 to 0 (registered).
- States per slot: DEAD_T (pre < DEAD) -> ON (DEAD <= pre <= DIV-1) -> next slot DEAD_T. No other states.
- Outputs are registered; an and seg reflect cur/pre of the previous cycle (1-cycle latency).
  - DEAD_T: an = all 1s; seg = 7'b1111111.
  - ON: an[cur] = 0, all other an bits = 1. seg = decode(data[cur]), or 7'b1111111 if blank[cur].
- Decode table, hex -> seg:
  - 0 -> 1000000, 1 -> 1111001, 2 -> 0100100, 3 -> 0110000
  - 4 -> 0011001, 5 -> 0010010, 6 -> 0000010, 7 -> 1111000
  - 8 -> 0000000, 9 -> 0010000, A -> 0001000, b -> 0000011
  - C -> 1000110, d -> 0100001, E -> 0000110, F -> 0001110
- Write: with wr_en=1 and wr_idx < NDIG, data[wr_idx] <= wr_data and blank[wr_idx] <= wr_blank at the clock edge. wr_idx >= NDIG is ignored.
- Write visibility: a write to the digit currently in ON is visible on seg 2 cycles after wr_en is sampled (register + output register).
- clr and wr_en in the same cycle: clr wins; every digit goes blank and the write is dropped.
- clr does not reset pre or cur; scanning continues uninterrupted.

Optional Feature:
SEG_SCAN_DP_EN
- Defined:
  - Adds input wr_dp (1) and output dp (1, active-low).
  - Each digit stores a dp bit, written with wr_en and cleared by clr/rst.
  - dp = ~dp_bit[cur] in ON; dp = 1 in DEAD_T and at reset.
  - dp follows the same 1-cycle output latency as seg.
- Undefined: no dp port and no dp storage.

Decomposition:
- Package seg_pkg holds:
  - SEG_BLANK = 7'b1111111
  - the 16-entry hex->segment constant table
  - the slot-state enum {DEAD_T, ON}
- Sub-module seg_hex_decode: combinational 4-bit -> 7-bit table lookup from seg_pkg. Instantiated once, fed data[cur].
- Everything else (storage, prescaler, scan, output registers) lives in seg_scan_ctrl.

Test Plan:
- Reset mid-slot with NDIG=4, DIV=8, DEAD=2: assert rst during ON of digit 2 -> an=1111 and seg=1111111 in the same cycle; after release, digit 0 ON at pre=2 (+1 cycle latency).
- Write 3,A,7,0 to digits 0..3 -> an cycles 1110, 1101, 1011, 0111. seg = 0110000, 0001000, 1111000, 1000000. Each ON window lasts 6 cycles, preceded by 2 cycles of an=1111.
- Write wr_blank=1 to digit 1 -> during slot 1, an=1101 and seg=1111111. Other digits unaffected.
- clr and wr_en (idx 0, data 5) in the same cycle -> all digits dark in the next scan; digit 0 not 0010010.
- Write wr_idx=5 with NDIG=4 -> no digit changes. frame_tick pulses exactly once every 32 cycles.
- With SEG_SCAN_DP_EN: write digit 2 with wr_dp=1 -> dp=0 only during the ON window of digit 2; dp=1 otherwise.
